// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and helpers for the matrix keypad scanner.
//   - scan_state_e  : controller states (idle, key pressed, lockout)
//   - frame_class_e : classification of one debounced scan frame
//   - calc_kw       : key code width for a ROWS x COLS matrix
//   - classify_frame: NONE / SINGLE / MULTI from a pressed-key bitmap
//   - onehot_to_code: bit position of the pressed key in a SINGLE frame
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LOCKOUT = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_SINGLE = 2'd1,
    FC_MULTI  = 2'd2
  } frame_class_e;

  // Widest supported matrix is 8x8, so bitmaps are handled as 64 bits.
  localparam int MAX_KEYS = 64;

  function automatic int calc_kw(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  function automatic frame_class_e classify_frame(input logic [MAX_KEYS-1:0] frame);
    if (frame == '0)
      return FC_NONE;
    else if ((frame & (frame - 64'd1)) == '0)
      return FC_SINGLE;
    else
      return FC_MULTI;
  endfunction

  function automatic logic [5:0] onehot_to_code(input logic [MAX_KEYS-1:0] frame);
    logic [5:0] code;
    code = '0;
    for (int i = 0; i < MAX_KEYS; i++)
      if (frame[i]) code = 6'(i);
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Keypad matrix lines plus the decoded key event bus.
//   row         : row lines, active-low (into the scanner)
//   col         : column drive, active-low (out of the scanner)
//   key_code    : code of the accepted key, col_idx*ROWS + row_idx
//   key_valid   : one-cycle pulse on press or auto-repeat
//   key_held    : level, accepted key currently held
//   key_release : one-cycle pulse when the accepted key is released
//   multi_err   : level, last debounced frame had more than one key
//   master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int KW = keypad_pkg::calc_kw(ROWS, COLS);

  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            key_release;
  logic            multi_err;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held, key_release, multi_err
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held, key_release, multi_err
  );

endinterface

// File: rtl/keypad_col_scan.sv
// keypad_col_scan
//   Round-robin column driver. Each column is held low for DWELL cycles.
//   clk           : system clock
//   reset         : asynchronous, active-low
//   col           : column drive, one bit low while scanning, all ones in reset
//   sample_strobe : last cycle of every column dwell
//   frame_strobe  : last cycle of the dwell on the final column
module keypad_col_scan #(
  parameter int COLS  = 4,
  parameter int DWELL = 1000
) (
  input  logic            clk,
  input  logic            reset,
  output logic [COLS-1:0] col,
  output logic            sample_strobe,
  output logic            frame_strobe
);

  localparam int DW = $clog2(DWELL);
  localparam int CW = $clog2(COLS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  logic [DW-1:0] dwell_cnt;
  logic [CW-1:0] col_idx;
  logic [CW-1:0] col_idx_next;
  logic          running;

  always_comb begin
    col_idx_next = (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);
  end

  // The first clock after reset starts the scan on column 0; from then on
  // the column advances whenever the dwell counter expires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running   <= 1'b0;
      dwell_cnt <= '0;
      col_idx   <= '0;
      col       <= '1;
    end else if (!running) begin
      running   <= 1'b1;
      dwell_cnt <= '0;
      col_idx   <= '0;
      col       <= ~(COLS'(1));
    end else if (dwell_cnt == DWELL_LAST) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx_next;
      col       <= ~(COLS'(1) << col_idx_next);
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  assign sample_strobe = running && (dwell_cnt == DWELL_LAST);
  assign frame_strobe  = sample_strobe && (col_idx == COL_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Parametrised matrix keypad scanner: scans columns, debounces whole
//   frames and reports one key with press, auto-repeat and release strobes.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : keypad_scanner_if master (row in, col/key outputs out)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DWELL      = 1000,
  parameter int DEBOUNCE   = 8,
  parameter int REPEAT_DLY = 0,
  parameter int REPEAT_PER = 10
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  localparam int KW    = calc_kw(ROWS, COLS);
  localparam int NKEYS = ROWS * COLS;

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] PRESSED = ST_PRESSED;
  localparam logic [1:0] LOCKOUT = ST_LOCKOUT;

  localparam logic [7:0]  DEB_MAX = 8'(DEBOUNCE);
  localparam logic [15:0] RPT_DLY = 16'(REPEAT_DLY);
  localparam logic [15:0] RPT_PER = 16'(REPEAT_PER);

  logic [ROWS-1:0]  row_meta;
  logic [ROWS-1:0]  row_sync;
  logic [COLS-1:0]  col;
  logic             sample_strobe;
  logic             frame_strobe;
  logic [NKEYS-1:0] frame_buf;
  logic [NKEYS-1:0] frame_now;
  logic [NKEYS-1:0] prev_frame;
  logic [7:0]       stable_cnt;
  logic [7:0]       stable_next;
  logic             stable;
  frame_class_e     fclass;
  logic [KW-1:0]    code_now;
  logic             hold_same;
  logic [1:0]       state;
  logic [15:0]      rep_cnt;
  logic [KW-1:0]    key_code;
  logic             key_valid;
  logic             key_held;
  logic             key_release;
  logic             multi_err;

  keypad_col_scan #(
    .COLS  (COLS),
    .DWELL (DWELL)
  ) u_col_scan (
    .clk           (clk),
    .reset         (reset),
    .col           (col),
    .sample_strobe (sample_strobe),
    .frame_strobe  (frame_strobe)
  );

  // Rows idle high, so the synchroniser also resets to all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= bus.row;
      row_sync <= row_meta;
    end
  end

  // Frame bitmap is stored active-high (1 = pressed) at col*ROWS + row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_buf <= '0;
    end else if (sample_strobe) begin
      for (int c = 0; c < COLS; c++)
        if (!col[c]) frame_buf[c*ROWS +: ROWS] <= ~row_sync;
    end
  end

  // At the frame strobe the final column is still being sampled, so it is
  // merged in directly rather than waiting for the buffer to catch up.
  always_comb begin
    frame_now = frame_buf;
    frame_now[(COLS-1)*ROWS +: ROWS] = ~row_sync;
  end

  always_comb begin
    if (frame_now != prev_frame)
      stable_next = 8'd1;
    else if (stable_cnt >= DEB_MAX)
      stable_next = DEB_MAX;
    else
      stable_next = stable_cnt + 8'd1;
  end

  assign stable    = (stable_next == DEB_MAX);
  assign fclass    = classify_frame(64'(frame_now));
  assign code_now  = KW'(onehot_to_code(64'(frame_now)));
  assign hold_same = (fclass == FC_SINGLE) && (code_now == key_code);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_cnt <= '0;
      prev_frame <= '0;
    end else if (frame_strobe) begin
      stable_cnt <= stable_next;
      prev_frame <= frame_now;
    end
  end

  // Key controller. Decisions are taken on the frame strobe using the
  // updated stability count. Repeats only count down while the latched key
  // is still seen alone, so a release in progress cannot fire a repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      multi_err   <= 1'b0;
      rep_cnt     <= '0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_strobe) begin
        if (stable) multi_err <= (fclass == FC_MULTI);
        case (state)
          IDLE: begin
            if (stable && fclass == FC_SINGLE) begin
              state     <= PRESSED;
              key_code  <= code_now;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              rep_cnt   <= RPT_DLY;
            end
          end
          PRESSED: begin
            if (stable && !hold_same) begin
              state       <= (fclass == FC_NONE) ? IDLE : LOCKOUT;
              key_release <= 1'b1;
              key_held    <= 1'b0;
            end else if (RPT_DLY != 16'd0 && hold_same) begin
              if (rep_cnt <= 16'd1) begin
                key_valid <= 1'b1;
                rep_cnt   <= RPT_PER;
              end else begin
                rep_cnt <= rep_cnt - 16'd1;
              end
            end
          end
          LOCKOUT: begin
            if (stable && fclass == FC_NONE) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.col         = col;
  assign bus.key_code    = key_code;
  assign bus.key_valid   = key_valid;
  assign bus.key_held    = key_held;
  assign bus.key_release = key_release;
  assign bus.multi_err   = multi_err;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner (4x4, DWELL=4, DEBOUNCE=3,
//   REPEAT_DLY=4, REPEAT_PER=2). A keypad model turns the pressed-key
//   bitmap into row levels for the active column. Expected key events are
//   queued with the frame in which they must appear; a monitor pops and
//   compares every key_valid/key_release pulse.
module tb_keypad_scanner;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int DWELL      = 4;
  localparam int DEBOUNCE   = 3;
  localparam int REPEAT_DLY = 4;
  localparam int REPEAT_PER = 2;

  typedef struct {
    bit is_release;
    int code;
    int frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  row_drv;
  logic [3:0]  prev_col = 4'hF;
  int          compared = 0;
  int          mismatched = 0;
  int          frame_no = 0;
  exp_t        sb[$];

  keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kif();

  keypad_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DWELL      (DWELL),
    .DEBOUNCE   (DEBOUNCE),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  always #5 clk = ~clk;

  // Pressed key at col c, row r pulls row r low while col c is low.
  always_comb begin
    row_drv = 4'hF;
    for (int c = 0; c < COLS; c++)
      if (!kif.col[c]) row_drv = row_drv & ~keys[c*4 +: 4];
  end
  assign kif.row = row_drv;

  // Frames are numbered when column 0 starts being driven; key pulses that
  // follow a frame strobe therefore carry the number of the next frame.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (kif.col == 4'b1110 && prev_col != 4'b1110) frame_no++;
    prev_col = kif.col;
    if (kif.key_valid || kif.key_release) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_event: valid=%0b release=%0b code=%0d frame=%0d, required no event",
                 kif.key_valid, kif.key_release, kif.key_code, frame_no);
      end else begin
        e = sb.pop_front();
        if ({kif.key_valid, kif.key_release} != {!e.is_release, e.is_release} ||
            int'(kif.key_code) != e.code || frame_no != e.frame) begin
          mismatched++;
          $display("[TB] FAIL key_event: valid=%0b release=%0b code=%0d frame=%0d, required release=%0b code=%0d frame=%0d",
                   kif.key_valid, kif.key_release, kif.key_code, frame_no,
                   e.is_release, e.code, e.frame);
        end
      end
      if (kif.key_valid) begin
        compared++;
        if (!kif.key_held) begin
          mismatched++;
          $display("[TB] FAIL valid_without_held: key_held=%0b, required 1", kif.key_held);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] k);
    keys = k;
  endtask

  task automatic expect_event(input bit rel, input int code, input int frame);
    exp_t e;
    e.is_release = rel;
    e.code       = code;
    e.frame      = frame;
    sb.push_back(e);
  endtask

  // Returns at the first negedge of the target frame.
  task automatic wait_frame(input int target);
    int guard;
    guard = 0;
    while (frame_no < target && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (frame_no < target) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_frame: frame %0d, required %0d", frame_no, target);
    end
  endtask

  initial begin
    int s;
    int a;
    int b;
    int c;
    int d;
    int e;
    int r;
    int fr;

    repeat (3) @(negedge clk);
    check_output("reset_col", 32'(kif.col), 32'hF);
    check_output("reset_code", 32'(kif.key_code), 0);
    check_output("reset_valid", 32'(kif.key_valid), 0);
    check_output("reset_held", 32'(kif.key_held), 0);
    check_output("reset_release", 32'(kif.key_release), 0);
    check_output("reset_multi", 32'(kif.multi_err), 0);
    reset = 1'b1;
    wait_frame(4);

    // Single key 9 (col 2, row 1) held 5 frames, then released.
    s = frame_no + 1;
    wait_frame(s);
    apply_stimulus(16'h0200);
    expect_event(1'b0, 9, s + 3);
    wait_frame(s + 2);
    check_output("press_not_yet_held", 32'(kif.key_held), 0);
    wait_frame(s + 4);
    check_output("press_held", 32'(kif.key_held), 1);
    check_output("press_code", 32'(kif.key_code), 9);
    r = s + 5;
    wait_frame(r);
    apply_stimulus(16'h0000);
    expect_event(1'b1, 9, r + 3);
    wait_frame(r + 4);
    check_output("release_held", 32'(kif.key_held), 0);
    check_output("release_code_kept", 32'(kif.key_code), 9);

    // Key 6 toggled every frame: never stable, no events.
    s = frame_no + 1;
    for (int i = 0; i < 6; i++) begin
      wait_frame(s + i);
      apply_stimulus((i % 2 == 0) ? 16'h0040 : 16'h0000);
      check_output("bounce_held", 32'(kif.key_held), 0);
    end
    wait_frame(s + 9);
    check_output("bounce_held_end", 32'(kif.key_held), 0);
    check_output("bounce_code_kept", 32'(kif.key_code), 9);

    // Keys 0 and 5 together: multi_err only, cleared by 3 NONE frames.
    s = frame_no + 1;
    wait_frame(s);
    apply_stimulus(16'h0021);
    wait_frame(s + 2);
    check_output("multi_not_yet", 32'(kif.multi_err), 0);
    wait_frame(s + 3);
    check_output("multi_set", 32'(kif.multi_err), 1);
    check_output("multi_held", 32'(kif.key_held), 0);
    r = s + 4;
    wait_frame(r);
    apply_stimulus(16'h0000);
    wait_frame(r + 2);
    check_output("multi_still_set", 32'(kif.multi_err), 1);
    wait_frame(r + 3);
    check_output("multi_cleared", 32'(kif.multi_err), 0);

    // Key 15 held 13 frames: press, then repeats after 4 then every 2.
    s = frame_no + 1;
    wait_frame(s);
    apply_stimulus(16'h8000);
    expect_event(1'b0, 15, s + 3);
    expect_event(1'b0, 15, s + 7);
    expect_event(1'b0, 15, s + 9);
    expect_event(1'b0, 15, s + 11);
    expect_event(1'b0, 15, s + 13);
    r = s + 13;
    wait_frame(r);
    apply_stimulus(16'h0000);
    expect_event(1'b1, 15, r + 3);
    wait_frame(r + 4);
    check_output("repeat_released", 32'(kif.key_held), 0);

    // Key 3, then key 7 added: release into lockout, no new press until
    // every key has been released long enough.
    s = frame_no + 1;
    wait_frame(s);
    apply_stimulus(16'h0008);
    expect_event(1'b0, 3, s + 3);
    a = s + 4;
    wait_frame(a);
    apply_stimulus(16'h0088);
    expect_event(1'b1, 3, a + 3);
    wait_frame(a + 4);
    check_output("lockout_multi", 32'(kif.multi_err), 1);
    check_output("lockout_held", 32'(kif.key_held), 0);
    b = a + 5;
    wait_frame(b);
    apply_stimulus(16'h0008);
    wait_frame(b + 4);
    check_output("lockout_single_multi", 32'(kif.multi_err), 0);
    check_output("lockout_single_held", 32'(kif.key_held), 0);
    c = b + 5;
    wait_frame(c);
    apply_stimulus(16'h0000);
    d = c + 4;
    wait_frame(d);
    apply_stimulus(16'h0008);
    expect_event(1'b0, 3, d + 3);
    e = d + 5;
    wait_frame(e);
    apply_stimulus(16'h0000);
    expect_event(1'b1, 3, e + 3);
    wait_frame(e + 4);

    // Reset mid-frame with key 9 held, then the press is debounced again.
    s = frame_no + 1;
    wait_frame(s);
    apply_stimulus(16'h0200);
    expect_event(1'b0, 9, s + 3);
    wait_frame(s + 4);
    check_output("pre_reset_held", 32'(kif.key_held), 1);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("async_reset_col", 32'(kif.col), 32'hF);
    check_output("async_reset_held", 32'(kif.key_held), 0);
    check_output("async_reset_code", 32'(kif.key_code), 0);
    check_output("async_reset_valid", 32'(kif.key_valid), 0);
    check_output("async_reset_multi", 32'(kif.multi_err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    fr = frame_no;
    expect_event(1'b0, 9, fr + 4);
    wait_frame(fr + 3);
    check_output("repress_not_yet", 32'(kif.key_held), 0);
    wait_frame(fr + 4);
    check_output("repress_held", 32'(kif.key_held), 1);
    r = fr + 6;
    wait_frame(r);
    apply_stimulus(16'h0000);
    expect_event(1'b1, 9, r + 3);
    wait_frame(r + 4);
    check_output("final_held", 32'(kif.key_held), 0);

    wait_frame(frame_no + 3);
    check_output("scoreboard_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
